alu4_driver: RTL
================

ALU4_DRIVER -- requirements
Module: alu4_driver

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req_valid, input, 1 bit: request present.
REQ-004 SHALL have port req_ready, output, 1 bit: driver can accept a request.
REQ-005 SHALL have ports req_a and req_b, input, 4 bits each: operands.
REQ-006 SHALL have port req_op, input, 3 bits: operation code.
- 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
REQ-007 SHALL have port req_acc, input, 1 bit: when set, use the accumulator in place of req_a.
REQ-008 SHALL have ports alu_a and alu_b, output, 4 bits each: registered operands driven to the ALU.
REQ-009 SHALL have port alu_op, output, 3 bits: registered opcode driven to the ALU.
REQ-010 SHALL have ports alu_result (input, 4 bits), alu_carry, alu_overflow and alu_zero (input, 1 bit each): combinational ALU outputs.
REQ-011 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-013 SHALL have port rsp_result, output, 4 bits, plus rsp_carry, rsp_overflow and rsp_zero, output, 1 bit each: captured ALU outputs.
REQ-014 SHALL have port acc, output, 4 bits: accumulator value.
REQ-015 SHALL have port ovf_count, output, 8 bits: saturating count of add/sub overflows.

Function
REQ-016 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-017 SHALL assert req_ready only in IDLE; rsp_valid only in RESP.
REQ-018 SHALL register operands in IDLE when req_valid && req_ready, then go to EXEC.
- alu_a = req_acc ? acc : req_a; alu_b = req_b; alu_op = req_op.
REQ-019 SHALL hold alu_a, alu_b and alu_op stable from accept until the next accept.
REQ-020 SHALL spend exactly one cycle in EXEC, then go to RESP.
- At the end of that cycle, capture alu_result/carry/overflow/zero into the rsp_* registers.
REQ-021 SHALL set acc to alu_result at the EXEC capture edge for ops 000-101; ops 110 and 111 leave acc unchanged.
REQ-022 SHALL increment ovf_count at the EXEC capture edge when alu_overflow=1 and the op is 000 or 001.
- Saturates at 255; never wraps.
REQ-023 SHALL hold rsp_* and rsp_valid stable in RESP while rsp_ready=0.
REQ-024 SHALL return to IDLE on the cycle rsp_valid && rsp_ready is sampled.
- No request is accepted on that same cycle.
REQ-025 SHALL give a latency of 2 cycles from the accept edge to rsp_valid high, and a minimum of 3 cycles per transaction.
REQ-026 SHALL ignore req_valid and all req_* inputs outside IDLE.
REQ-027 SHALL pass ALU flag values through unmodified; no recomputation inside the driver.

Reset
REQ-028 SHALL, while rst_n=0, immediately force IDLE and clear the outputs, independent of clk.
- Cleared: alu_a, alu_b, alu_op, rsp_result, rsp flags, acc and ovf_count all 0; rsp_valid=0.
REQ-029 SHALL discard an in-flight transaction when reset asserts in EXEC or RESP; no response is produced after release.
REQ-030 SHALL assert req_ready in the first cycle after rst_n deasserts.

Verification (bench connects a behavioural 4-bit ALU model to alu_*)
REQ-031 SHALL cover signed-add overflow:
- Stimulus: a=0111, b=0001, op=000, accepted at cycle T.
- Response: at T+2, rsp_valid=1, rsp_result=1000, rsp_overflow=1; ovf_count=1, acc=1000.
REQ-032 SHALL cover accumulator chaining:
- Stimulus: after reset, three requests with req_acc=1, b=0011, op=000.
- Response: acc steps 0011, 0110, 1001; the third rsp_overflow=1.
REQ-033 SHALL cover signed compare:
- Stimulus: acc=0101, then a=0010, b=0101, op=110.
- Response: rsp_result=0001; acc stays 0101.
REQ-034 SHALL cover response backpressure:
- Stimulus: rsp_ready=0 for 5 cycles in RESP while req_valid=1.
- Response: rsp_* stable, req_ready=0, no accept; after rsp_ready=1, IDLE next cycle.
REQ-035 SHALL cover reset mid-operation:
- Stimulus: rst_n low during EXEC.
- Response: all outputs 0 immediately; no rsp_valid after release; req_ready=1 the cycle after release.
REQ-036 SHALL cover overflow-count saturation:
- Stimulus: 260 overflowing subs (1000 - 0001).
- Response: ovf_count holds at 255.

Source files
------------

// File: rtl/alu4_driver.sv
// Request/response driver for an external combinational 4-bit ALU.
// Registers operands, captures ALU results, keeps an accumulator and a saturating overflow count.
module alu4_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [2:0] req_op,
    input  logic       req_acc,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_overflow,
    output logic       rsp_zero,
    output logic [3:0] acc,
    output logic [7:0] ovf_count
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [3:0] rsp_result_q, rsp_result_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_overflow_q, rsp_overflow_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic [3:0] acc_q, acc_d;
    logic [7:0] ovf_count_q, ovf_count_d;

    // NOTE: every register uses <= so all of them update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            rsp_result_q   <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_zero_q     <= 1'b0;
            acc_q          <= '0;
            ovf_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            rsp_result_q   <= rsp_result_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_zero_q     <= rsp_zero_d;
            acc_q          <= acc_d;
            ovf_count_q    <= ovf_count_d;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults first, so no path through the case leaves a value unassigned (no latches).
        state_d        = state_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        rsp_result_d   = rsp_result_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_zero_d     = rsp_zero_q;
        acc_d          = acc_q;
        ovf_count_d    = ovf_count_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_a_d  = req_acc ? acc_q : req_a;
                    alu_b_d  = req_b;
                    alu_op_d = req_op;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d   = alu_result;
                rsp_carry_d    = alu_carry;
                rsp_overflow_d = alu_overflow;
                rsp_zero_d     = alu_zero;
                // Compare ops produce a flag, not a value worth accumulating.
                if (alu_op_q <= OP_XOR) begin
                    acc_d = alu_result;
                end
                if (alu_overflow && (alu_op_q == OP_ADD || alu_op_q == OP_SUB)
                    && ovf_count_q != 8'hFF) begin
                    ovf_count_d = ovf_count_q + 8'd1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_zero     = rsp_zero_q;
    assign acc          = acc_q;
    assign ovf_count    = ovf_count_q;

endmodule
